// File: rtl/usb_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_uart_pkg
//  Description : Shared types and helpers for the USB-UART transmit FIFO:
//                output FSM state encoding and pointer-width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_uart_pkg;

  // Output stage: IDLE has nothing offered, PRESENT holds uart_we high.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } tx_state_e;

  localparam int unsigned C_MIN_DEPTH = 4;
  localparam int unsigned C_MAX_DEPTH = 256;

  // One extra pointer bit beyond the address distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : DEPTH x 8 storage, one write port and one registered read
//                port, shaped to map onto iCE40 block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  // The array itself carries no reset so it stays a pure RAM macro.
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; holds its value between reads, cleared on reset
  // so the downstream byte lane starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
    end else if (i_re) begin
      rdata_q <= mem[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/usb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : usb_uart_tx_fifo
//  Description : Byte FIFO feeding a usb_uart transmitter. Producer pushes
//                with in_valid/in_ready; the head byte is presented on
//                uart_di with uart_we held until the UART drops uart_wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_uart_tx_fifo
  import usb_uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             uart_we,
  output logic [7:0]       uart_di,
  input  logic             uart_wait,
  output logic [PTR_W-1:0] count,
  output logic             overflow
);

  localparam int ADDR_W = PTR_W - 1;

  if ((DEPTH < C_MIN_DEPTH) || (DEPTH > C_MAX_DEPTH) ||
      ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("usb_uart_tx_fifo: DEPTH must be a power of two in 4..256");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  tx_state_e        state_q, state_d;
  logic             load_q, load_d;
  logic             overflow_q, overflow_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Same address with differing wrap bits means every slot is occupied.
  assign w_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  // Full refuses the push regardless of a pop in the same cycle.
  assign w_push  = in_valid && !w_full;

  assign in_ready = !w_full;
  assign count    = wr_ptr_q - rd_ptr_q;
  assign uart_we  = (state_q == ST_PRESENT);
  assign overflow = overflow_q;

  // Output FSM: a pop from IDLE lands in the RAM read register on the next
  // edge (load_q), and uart_we rises one edge later together with that byte.
  // In PRESENT an accepted byte is immediately replaced by the next head.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_q) begin
          state_d = ST_PRESENT;
        end else if (!w_empty) begin
          w_pop  = 1'b1;
          load_d = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (!uart_wait) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer advance and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + (w_push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d   = rd_ptr_q + (w_pop  ? PTR_W'(1) : PTR_W'(0));
    overflow_d = overflow_q || (in_valid && w_full);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= ST_IDLE;
      load_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      load_q     <= load_d;
      overflow_q <= overflow_d;
    end
  end

  // uart_di is the RAM read register itself, so it changes only on a pop.
  fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo_ram (
    .clk     (clk_48mhz),
    .rst     (reset),
    .i_we    (w_push),
    .i_waddr (wr_ptr_q[ADDR_W-1:0]),
    .i_wdata (in_data),
    .i_re    (w_pop),
    .i_raddr (rd_ptr_q[ADDR_W-1:0]),
    .o_rdata (uart_di)
  );

endmodule
`default_nettype wire

// File: tb/tb_usb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_usb_uart_tx_fifo
//  Description : Self-checking bench for usb_uart_tx_fifo (DEPTH 16 and 4)
//                against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_uart_tx_fifo;

  logic clk_48mhz = 1'b0;
  always #5 clk_48mhz = ~clk_48mhz;

  logic       reset;
  logic       in_valid, in_ready, uart_we, uart_wait, overflow;
  logic [7:0] in_data, uart_di;
  logic [4:0] count;
  logic       in_valid4, in_ready4, uart_we4, uart_wait4, overflow4;
  logic [7:0] in_data4, uart_di4;
  logic [2:0] count4;

  usb_uart_tx_fifo #(.DEPTH(16)) dut (
    .clk_48mhz (clk_48mhz), .reset (reset),
    .in_valid  (in_valid),  .in_data (in_data), .in_ready (in_ready),
    .uart_we   (uart_we),   .uart_di (uart_di), .uart_wait (uart_wait),
    .count     (count),     .overflow (overflow)
  );

  usb_uart_tx_fifo #(.DEPTH(4)) dut4 (
    .clk_48mhz (clk_48mhz), .reset (reset),
    .in_valid  (in_valid4), .in_data (in_data4), .in_ready (in_ready4),
    .uart_we   (uart_we4),  .uart_di (uart_di4), .uart_wait (uart_wait4),
    .count     (count4),    .overflow (overflow4)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: stored bytes, byte being fetched, byte offered.
  int         m_depth;
  logic [7:0] m_q[$];
  bit         m_loading, m_present, m_ovf;
  logic [7:0] m_di;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         m_pushes;

  function automatic void m_step(input bit v, input logic [7:0] d, input bit w);
    bit can_push;
    can_push = v && (m_q.size() < m_depth);
    if (v && !can_push) m_ovf = 1'b1;
    if (m_present) begin
      if (!w) begin
        if (m_q.size() > 0) m_di = m_q.pop_front();
        else m_present = 1'b0;
      end
    end else if (m_loading) begin
      m_loading = 1'b0;
      m_present = 1'b1;
    end else if (m_q.size() > 0) begin
      m_di      = m_q.pop_front();
      m_loading = 1'b1;
    end
    if (can_push) begin
      m_q.push_back(d);
      exp_q.push_back(d);
      m_pushes++;
    end
  endfunction

  // One clock: record what the UART sink takes, then advance the model.
  task automatic tick(input bit use4);
    bit v, w, we;
    logic [7:0] d, di;
    @(negedge clk_48mhz);
    if (use4) begin v = in_valid4; d = in_data4; w = uart_wait4; we = uart_we4; di = uart_di4; end
    else      begin v = in_valid;  d = in_data;  w = uart_wait;  we = uart_we;  di = uart_di;  end
    if (we && !w) rx_q.push_back(di);
    @(posedge clk_48mhz);
    m_step(v, d, w);
    #1;
  endtask

  task automatic do_reset(input int depth);
    in_valid = 0; in_valid4 = 0; uart_wait = 0; uart_wait4 = 0;
    in_data = 8'h00; in_data4 = 8'h00;
    reset = 1;
    @(posedge clk_48mhz);
    #1;
    reset = 0;
    m_depth = depth; m_q.delete(); m_loading = 0; m_present = 0; m_ovf = 0;
    m_di = 8'h00; exp_q.delete(); rx_q.delete(); m_pushes = 0;
  endtask

  task automatic test_reset();
    do_reset(16);
    checks++; if (uart_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", uart_we); end
    checks++; if (uart_di !== 8'h00) begin errors++; $display("FAIL reset_di: got %h want 00", uart_di); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (count4 !== 3'd0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_dut4: count %0d ready %b want 0/1", count4, in_ready4); end
  endtask

  task automatic test_latency();
    do_reset(16);
    in_valid = 1; in_data = 8'h48; uart_wait = 0;
    tick(0);
    in_valid = 0;
    checks++; if (count !== 5'd1 || uart_we !== 1'b0) begin errors++; $display("FAIL lat_e0: count %0d we %b want 1/0", count, uart_we); end
    tick(0);
    checks++; if (uart_we !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL lat_e1: we %b count %0d want 0/0", uart_we, count); end
    tick(0);
    checks++; if (uart_we !== 1'b1 || uart_di !== 8'h48) begin errors++; $display("FAIL lat_e2: we %b di %h want 1/48", uart_we, uart_di); end
    tick(0);
    checks++; if (uart_we !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL lat_e3: we %b count %0d want 0/0", uart_we, count); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h48) begin errors++; $display("FAIL lat_rx: got %0d bytes want one 48", rx_q.size()); end
  endtask

  task automatic test_hello();
    string s;
    int busy, idx;
    logic [7:0] prev_di;
    bit prev_hold, acc;
    s = "Hello World!\n";
    busy = 0; idx = 0; prev_hold = 0; prev_di = 8'h00;
    do_reset(16);
    for (int cyc = 0; cyc < 400 && rx_q.size() < 13; cyc++) begin
      in_valid  = (idx < 13);
      in_data   = (idx < 13) ? s[idx] : 8'h00;
      uart_wait = (busy > 0);
      checks++; if (uart_we !== m_present) begin errors++; $display("FAIL hello_we cyc %0d: got %b want %b", cyc, uart_we, m_present); end
      checks++; if (count !== 5'(m_q.size())) begin errors++; $display("FAIL hello_count cyc %0d: got %0d want %0d", cyc, count, m_q.size()); end
      if (prev_hold && uart_we) begin
        checks++; if (uart_di !== prev_di) begin errors++; $display("FAIL hello_stable cyc %0d: got %h want %h", cyc, uart_di, prev_di); end
      end
      prev_hold = uart_we && uart_wait;
      prev_di   = uart_di;
      acc       = uart_we && !uart_wait;
      tick(0);
      if (in_valid) idx++;
      if (acc) busy = 5; else if (busy > 0) busy--;
    end
    in_valid = 0; uart_wait = 0;
    checks++; if (rx_q.size() != 13) begin errors++; $display("FAIL hello_len: got %0d want 13", rx_q.size()); end
    for (int i = 0; i < 13 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'(s[i])) begin errors++; $display("FAIL hello_byte %0d: got %h want %h", i, rx_q[i], s[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset(16);
    uart_wait = 1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_start: got %b want 0", overflow); end
    for (int i = 0; i < 18; i++) begin
      in_valid = 1; in_data = 8'h10 + 8'(i);
      checks++; if (in_ready !== (m_q.size() < 16)) begin errors++; $display("FAIL ovf_ready %0d: got %b want %b", i, in_ready, m_q.size() < 16); end
      checks++; if (count !== 5'(m_q.size())) begin errors++; $display("FAIL ovf_count %0d: got %0d want %0d", i, count, m_q.size()); end
      tick(0);
    end
    in_valid = 0;
    checks++; if (count !== 5'd16 || in_ready !== 1'b0) begin errors++; $display("FAIL ovf_full: count %0d ready %b want 16/0", count, in_ready); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (uart_we !== 1'b1 || uart_di !== 8'h10) begin errors++; $display("FAIL ovf_head: we %b di %h want 1/10", uart_we, uart_di); end
    uart_wait = 0;
    for (int k = 0; k < 17; k++) begin
      checks++; if (uart_we !== 1'b1) begin errors++; $display("FAIL ovf_stream %0d: we %b want 1", k, uart_we); end
      tick(0);
    end
    checks++; if (uart_we !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL ovf_drained: we %b count %0d want 0/0", uart_we, count); end
    checks++; if (rx_q.size() != 17) begin errors++; $display("FAIL ovf_len: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_byte %0d: got %h want %h", i, rx_q[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(16);
    uart_wait = 1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_data = 8'h30 + 8'(i);
      tick(0);
    end
    in_valid = 0;
    checks++; if (count !== 5'd8 || uart_we !== 1'b1) begin errors++; $display("FAIL b2b_setup: count %0d we %b want 8/1", count, uart_we); end
    in_valid = 1; in_data = 8'hA5; uart_wait = 0;
    tick(0);
    in_valid = 0;
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL b2b_count: got %0d want 8", count); end
    for (int k = 0; k < 20; k++) tick(0);
    checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL b2b_len: got %0d want 10", rx_q.size()); end
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL b2b_byte %0d: got %h want %h", i, rx_q[i], 8'h30 + 8'(i)); end
    end
    if (rx_q.size() == 10) begin
      checks++; if (rx_q[9] !== 8'hA5) begin errors++; $display("FAIL b2b_last: got %h want a5", rx_q[9]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(16);
    uart_wait = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = 8'h50 + 8'(i);
      tick(0);
    end
    in_valid = 0;
    checks++; if (count !== 5'd5 || uart_we !== 1'b1) begin errors++; $display("FAIL rmid_setup: count %0d we %b want 5/1", count, uart_we); end
    do_reset(16);
    checks++; if (uart_we !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL rmid_after: we %b count %0d want 0/0", uart_we, count); end
    checks++; if (overflow !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_flags: ovf %b ready %b want 0/1", overflow, in_ready); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (uart_we !== 1'b0) begin errors++; $display("FAIL rmid_stale %0d: we %b want 0", k, uart_we); end
      tick(0);
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rmid_rx: got %0d bytes want 0", rx_q.size()); end
  endtask

  task automatic test_random();
    do_reset(4);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid4  = ($urandom_range(3) != 0);
      in_data4   = 8'($urandom);
      uart_wait4 = ($urandom_range(2) == 0);
      checks++; if (count4 !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, count4, m_q.size()); end
      checks++; if (in_ready4 !== (m_q.size() < 4)) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, in_ready4, m_q.size() < 4); end
      checks++; if (uart_we4 !== m_present) begin errors++; $display("FAIL rnd_we cyc %0d: got %b want %b", cyc, uart_we4, m_present); end
      if (m_present) begin
        checks++; if (uart_di4 !== m_di) begin errors++; $display("FAIL rnd_di cyc %0d: got %h want %h", cyc, uart_di4, m_di); end
      end
      checks++; if (count4 > 3'd4) begin errors++; $display("FAIL rnd_bound cyc %0d: count %0d exceeds 4", cyc, count4); end
      tick(1);
    end
    in_valid4 = 0; uart_wait4 = 0;
    for (int k = 0; k < 12; k++) tick(1);
    checks++; if (overflow4 !== m_ovf) begin errors++; $display("FAIL rnd_ovf: got %b want %b", overflow4, m_ovf); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_order %0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if ((m_pushes / 4) < 100) begin errors++; $display("FAIL rnd_wraps: got %0d want >=100", m_pushes / 4); end
  endtask

  initial begin
    reset = 1;
    in_valid = 0; in_valid4 = 0; uart_wait = 0; uart_wait4 = 0;
    in_data = 8'h00; in_data4 = 8'h00;
    test_reset();
    test_latency();
    test_hello();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded 2 ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
